// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// datapath word width and the address bit that marks an unaligned access.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ERR  = 2'b10
    } mem_state_t;

    localparam int WORD_W         = 16;
    localparam int ADDR_ALIGN_BIT = 0;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Free-running busy-cycle counter with synchronous clear and count enable.
// It flags when the count equals TERMINAL_COUNT so that the owner can
// abandon a memory transaction that never gets acknowledged.
module mem_timeout_ctr #(
    parameter int CNT_W          = 7,
    parameter int TERMINAL_COUNT = 63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL_COUNT);

    logic [CNT_W-1:0] count;

    // Clear has priority over enable so a completing transaction always
    // leaves the counter at zero for the next one.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TERM);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Non-memory instructions pass straight to
// writeback one cycle later; loads and stores run a req/ack handshake with a
// variable-latency data memory while upstream is stalled. Unaligned accesses
// and transactions that never get acknowledged send the stage into a sticky
// error state that only reset can leave.
// TIMEOUT_CYCLES must be representable in CNT_W bits (2**CNT_W > TIMEOUT_CYCLES).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_aluOut,
    input  logic [WORD_W-1:0] ex_wdata,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              flush,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_mem_out,
    output logic [WORD_W-1:0] wb_aluOut,
    output logic              err
);

    mem_state_t state;
    mem_state_t next_state;

    logic accept;
    logic memop;
    logic aligned;
    logic start_mem;
    logic retire_alu;
    logic retire_mem;
    logic ctr_clear;
    logic ctr_enable;
    logic ctr_terminal;

    // A store wins when both read and write are flagged, which falls out of
    // latching ex_memwrite as the write-enable.
    assign memop      = ex_memread | ex_memwrite;
    assign accept     = (state == IDLE) & ex_valid & ~flush;
    assign aligned    = ~ex_aluOut[ADDR_ALIGN_BIT];
    assign start_mem  = accept & memop & aligned;
    assign retire_alu = accept & ~memop;
    assign retire_mem = (state == BUSY) & mem_ack;

    mem_timeout_ctr #(
        .CNT_W          (CNT_W),
        .TERMINAL_COUNT (TIMEOUT_CYCLES - 1)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (ctr_clear),
        .enable   (ctr_enable),
        .terminal (ctr_terminal)
    );

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/stall outputs. Stall never looks at mem_ack,
    // which keeps the memory response off the combinational path upstream.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        err        = 1'b0;
        ctr_clear  = 1'b1;
        ctr_enable = 1'b0;
        case (state)
            IDLE: begin
                if (accept && memop) begin
                    if (aligned) begin
                        next_state = BUSY;
                        stall      = 1'b1;
                    end else begin
                        next_state = ERR;
                    end
                end
            end
            BUSY: begin
                stall      = 1'b1;
                mem_req    = 1'b1;
                ctr_clear  = 1'b0;
                ctr_enable = 1'b1;
                if (mem_ack) begin
                    next_state = IDLE;
                    ctr_clear  = 1'b1;
                end else if (ctr_terminal) begin
                    next_state = ERR;
                end
            end
            ERR: begin
                stall = 1'b1;
                err   = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request registers: captured once at acceptance so address, data and
    // direction stay stable for the whole time mem_req is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else if (start_mem) begin
            mem_addr  <= ex_aluOut;
            mem_wdata <= ex_wdata;
            mem_we    <= ex_memwrite;
        end
    end

    // Writeback registers: wb_valid pulses for one cycle per retired
    // instruction; ALU-only instructions leave the load data untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_mem_out <= '0;
            wb_aluOut  <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (retire_alu) begin
                wb_valid  <= 1'b1;
                wb_aluOut <= ex_aluOut;
            end else if (retire_mem) begin
                wb_valid   <= 1'b1;
                wb_aluOut  <= mem_addr;
                wb_mem_out <= mem_we ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios followed by randomized
// instructions, with a memory responder and a transaction-level model of
// expected writeback, stall and error behaviour.
module tb_mem_access_stage;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [15:0] ex_aluOut = '0;
    logic [15:0] ex_wdata = '0;
    logic        ex_memread = 1'b0;
    logic        ex_memwrite = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        wb_valid;
    logic [15:0] wb_mem_out;
    logic [15:0] wb_aluOut;
    logic        err;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] exp_wb_mem_out = '0;
    logic [15:0] mem_model [logic [15:0]];

    mem_access_stage #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_aluOut   (ex_aluOut),
        .ex_wdata    (ex_wdata),
        .ex_memread  (ex_memread),
        .ex_memwrite (ex_memwrite),
        .flush       (flush),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .wb_valid    (wb_valid),
        .wb_mem_out  (wb_mem_out),
        .wb_aluOut   (wb_aluOut),
        .err         (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Backstop so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] mem_lookup(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 16'hC3C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        ex_valid    = 1'b0;
        flush       = 1'b0;
        ex_memread  = 1'b0;
        ex_memwrite = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        idleInputs();
        mem_ack = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_stall",      16'(stall),    16'd0);
        checkOutput("rst_mem_req",    16'(mem_req),  16'd0);
        checkOutput("rst_mem_we",     16'(mem_we),   16'd0);
        checkOutput("rst_mem_addr",   mem_addr,      16'd0);
        checkOutput("rst_mem_wdata",  mem_wdata,     16'd0);
        checkOutput("rst_wb_valid",   16'(wb_valid), 16'd0);
        checkOutput("rst_wb_mem_out", wb_mem_out,    16'd0);
        checkOutput("rst_wb_aluOut",  wb_aluOut,     16'd0);
        checkOutput("rst_err",        16'(err),      16'd0);
        rst_n = 1'b1;
        exp_wb_mem_out = '0;
    endtask

    // Error state must hold regardless of what upstream presents.
    task automatic checkErrHold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ex_valid    = 1'($urandom);
            flush       = 1'($urandom);
            ex_memread  = 1'($urandom);
            ex_memwrite = 1'($urandom);
            ex_aluOut   = 16'($urandom) & 16'hFFFE;
            mem_ack     = 1'($urandom);
            #1;
            checkOutput("err_hold_err",      16'(err),      16'd1);
            checkOutput("err_hold_stall",    16'(stall),    16'd1);
            checkOutput("err_hold_mem_req",  16'(mem_req),  16'd0);
            checkOutput("err_hold_wb_valid", 16'(wb_valid), 16'd0);
        end
        mem_ack = 1'b0;
        idleInputs();
    endtask

    task automatic strayAck();
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'($urandom);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checkOutput("stray_wb_valid",   16'(wb_valid), 16'd0);
        checkOutput("stray_wb_mem_out", wb_mem_out,    exp_wb_mem_out);
        checkOutput("stray_mem_req",    16'(mem_req),  16'd0);
    endtask

    // Present one instruction in IDLE and follow it to retirement or error.
    // ack_at is the BUSY cycle (1-based) carrying mem_ack; 0 means never.
    // Returns 1 in went_err when the stage ended in the error state.
    task automatic applyStimulus(input logic valid, input logic rd, input logic wr,
                                 input logic fl, input logic [15:0] addr,
                                 input logic [15:0] wdata, input int ack_at,
                                 input bit noise, output bit went_err);
        logic accepted;
        logic is_memop;
        logic [15:0] exp_data;
        bit done;
        went_err = 1'b0;
        accepted = valid & ~fl;
        is_memop = rd | wr;
        @(negedge clk);
        #1;
        checkOutput("wb_valid_idle", 16'(wb_valid), 16'd0);
        ex_valid    = valid;
        ex_memread  = rd;
        ex_memwrite = wr;
        flush       = fl;
        ex_aluOut   = addr;
        ex_wdata    = wdata;
        #1;
        if (accepted && is_memop && !addr[0])
            checkOutput("stall_accept_mem", 16'(stall), 16'd1);
        else if (!(accepted && is_memop))
            checkOutput("stall_accept_alu", 16'(stall), 16'd0);
        @(negedge clk);
        if (!accepted) begin
            idleInputs();
            #1;
            checkOutput("noacc_wb_valid", 16'(wb_valid), 16'd0);
            checkOutput("noacc_mem_req",  16'(mem_req),  16'd0);
            checkOutput("noacc_stall",    16'(stall),    16'd0);
            checkOutput("noacc_err",      16'(err),      16'd0);
        end else if (!is_memop) begin
            idleInputs();
            #1;
            checkOutput("alu_wb_valid",   16'(wb_valid), 16'd1);
            checkOutput("alu_wb_aluOut",  wb_aluOut,     addr);
            checkOutput("alu_wb_mem_out", wb_mem_out,    exp_wb_mem_out);
            checkOutput("alu_stall",      16'(stall),    16'd0);
            checkOutput("alu_mem_req",    16'(mem_req),  16'd0);
        end else if (addr[0]) begin
            idleInputs();
            #1;
            checkOutput("unal_err",      16'(err),      16'd1);
            checkOutput("unal_stall",    16'(stall),    16'd1);
            checkOutput("unal_mem_req",  16'(mem_req),  16'd0);
            checkOutput("unal_wb_valid", 16'(wb_valid), 16'd0);
            went_err = 1'b1;
        end else begin
            done = 1'b0;
            exp_data = wr ? 16'd0 : mem_lookup(addr);
            for (int c = 1; c <= TMO && !done; c++) begin
                if (noise) begin
                    ex_valid    = 1'($urandom);
                    flush       = 1'($urandom);
                    ex_memread  = 1'($urandom);
                    ex_memwrite = 1'($urandom);
                    ex_aluOut   = 16'($urandom);
                    ex_wdata    = 16'($urandom);
                end else begin
                    idleInputs();
                end
                #1;
                checkOutput("busy_mem_req",   16'(mem_req),  16'd1);
                checkOutput("busy_stall",     16'(stall),    16'd1);
                checkOutput("busy_mem_addr",  mem_addr,      addr);
                checkOutput("busy_mem_we",    16'(mem_we),   16'(wr));
                checkOutput("busy_mem_wdata", mem_wdata,     wdata);
                checkOutput("busy_wb_valid",  16'(wb_valid), 16'd0);
                if (c == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = wr ? 16'($urandom) : mem_lookup(mem_addr);
                    if (wr) mem_model[addr] = wdata;
                end
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                if (c == ack_at) begin
                    idleInputs();
                    #1;
                    checkOutput("done_wb_valid",   16'(wb_valid), 16'd1);
                    checkOutput("done_wb_aluOut",  wb_aluOut,     addr);
                    checkOutput("done_wb_mem_out", wb_mem_out,    exp_data);
                    checkOutput("done_mem_req",    16'(mem_req),  16'd0);
                    checkOutput("done_stall",      16'(stall),    16'd0);
                    checkOutput("done_err",        16'(err),      16'd0);
                    exp_wb_mem_out = exp_data;
                    done = 1'b1;
                end
            end
            if (!done) begin
                idleInputs();
                #1;
                checkOutput("tmo_err",      16'(err),      16'd1);
                checkOutput("tmo_stall",    16'(stall),    16'd1);
                checkOutput("tmo_mem_req",  16'(mem_req),  16'd0);
                checkOutput("tmo_wb_valid", 16'(wb_valid), 16'd0);
                went_err = 1'b1;
            end
        end
    endtask

    initial begin
        bit e;
        int kind;
        logic [15:0] a;
        mem_model[16'h0040] = 16'hBEEF;
        doReset();

        // Stray ack straight out of reset.
        strayAck();
        // Non-memory op.
        applyStimulus(1, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, e);
        // Load, ack on the third request cycle.
        applyStimulus(1, 1, 0, 0, 16'h0040, 16'h0000, 3, 0, e);
        // Store, ack on the first request cycle, then read it back.
        applyStimulus(1, 0, 1, 0, 16'h0010, 16'hA5A5, 1, 0, e);
        applyStimulus(1, 1, 0, 0, 16'h0010, 16'h0000, 2, 0, e);
        // Read+write together behaves as a store.
        applyStimulus(1, 1, 1, 0, 16'h0020, 16'h5A5A, 2, 0, e);
        // Non-memory op keeps the previous load data.
        applyStimulus(1, 0, 0, 0, 16'h0041, 16'h0000, 0, 0, e);
        // Unaligned load.
        applyStimulus(1, 1, 0, 0, 16'h0041, 16'h0000, 0, 0, e);
        checkErrHold(4);
        doReset();
        // Timeout with no ack, then ack on the last allowed cycle.
        applyStimulus(1, 1, 0, 0, 16'h0080, 16'h0000, 0, 0, e);
        checkErrHold(2);
        doReset();
        applyStimulus(1, 1, 0, 0, 16'h0080, 16'h0000, TMO, 0, e);
        // Flushed load, invalid op, and a load with flush noise while busy.
        applyStimulus(1, 1, 0, 1, 16'h0040, 16'h0000, 1, 0, e);
        applyStimulus(0, 1, 0, 0, 16'h0040, 16'h0000, 1, 0, e);
        applyStimulus(1, 1, 0, 0, 16'h0040, 16'h0000, 4, 1, e);
        // Reset in the middle of a transaction, then a late ack.
        @(negedge clk);
        ex_valid = 1'b1; ex_memread = 1'b1; ex_aluOut = 16'h0042;
        @(negedge clk);
        idleInputs();
        @(negedge clk);
        doReset();
        strayAck();

        // Randomized instruction mix.
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 9);
            a = 16'($urandom) & 16'h00FE;
            e = 1'b0;
            case (kind)
                0, 1: applyStimulus(1, 0, 0, 0, 16'($urandom), 16'($urandom), 0, 1'($urandom), e);
                2, 3: applyStimulus(1, 1, 0, 0, a, 16'($urandom), $urandom_range(1, 6), 1'($urandom), e);
                4, 5: applyStimulus(1, 1'($urandom), 1, 0, a, 16'($urandom), $urandom_range(1, TMO), 1'($urandom), e);
                6:    applyStimulus(1, 1, 1'($urandom), 1, a, 16'($urandom), 1, 0, e);
                7:    applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), 1, 0, e);
                8:    strayAck();
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        applyStimulus(1, 1'($urandom), 1, 0, a | 16'h0001, 16'($urandom), 1, 0, e);
                    else
                        applyStimulus(1, 1, 0, 0, a, 16'($urandom), $urandom_range(TMO + 1, TMO + 4), 1'($urandom), e);
                end
            endcase
            if (e) begin
                checkErrHold(2);
                doReset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
